seg7_reader: RTL and testbench



---
 rtl/seg7_reader.sv | 134 +++++++++++++
 tb/tb_seg7_reader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/seg7_reader.sv
// seg7_reader
//   Monitors a two-digit, active-low, common-anode seven-segment bus and
//   recovers the number shown. Each pattern must be stable for STABLE_CYCLES
//   clock edges before it is accepted. Accepted patterns are decoded to BCD and
//   binary, and illegal glyphs and non-sequential count steps are flagged.
//
// Ports
//   CK       in   clock, rising edge
//   RS       in   asynchronous reset, active low
//   HEX0     in   [7:0] units segments, bit7 = dp, bits6..0 = g..a
//   HEX1     in   [7:0] tens segments, same encoding
//   BCD0     out  [3:0] accepted units digit
//   BCD1     out  [3:0] accepted tens digit
//   VAL      out  [6:0] accepted value, BCD1*10 + BCD0
//   VALID    out  one-cycle pulse on acceptance of a new legal value
//   ERR      out  one-cycle pulse on acceptance of an illegal pattern
//   SEQ_ERR  out  one-cycle pulse with VALID when VAL is not the expected successor
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned MAX_VAL       = 99
) (
    input  logic       CK,
    input  logic       RS,
    input  logic [7:0] HEX0,
    input  logic [7:0] HEX1,
    output logic [3:0] BCD0,
    output logic [3:0] BCD1,
    output logic [6:0] VAL,
    output logic       VALID,
    output logic       ERR,
    output logic       SEQ_ERR
);

    localparam logic [7:0] SC   = 8'(STABLE_CYCLES);
    localparam logic [6:0] VMAX = 7'(MAX_VAL);

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t      state;
    logic [13:0] samp;       // dp bits are masked, so only g..a of each digit is held
    logic [7:0]  cnt;
    logic [13:0] last_pat;
    logic        last_ok;
    logic        have_prev;

    logic [13:0] cur;
    logic        same;
    logic        fresh;
    logic [4:0]  d0;
    logic [4:0]  d1;
    logic        legal;
    logic [6:0]  newval;
    logic [6:0]  expval;

    // Returns {legal, digit}. A blank is legal only where blank_zero is set.
    function automatic logic [4:0] dec(input logic [6:0] g, input logic blank_zero);
        logic [4:0] r;
        case (g)
            7'h40:   r = {1'b1, 4'd0};
            7'h79:   r = {1'b1, 4'd1};
            7'h24:   r = {1'b1, 4'd2};
            7'h30:   r = {1'b1, 4'd3};
            7'h19:   r = {1'b1, 4'd4};
            7'h12:   r = {1'b1, 4'd5};
            7'h02:   r = {1'b1, 4'd6};
            7'h78:   r = {1'b1, 4'd7};
            7'h00:   r = {1'b1, 4'd8};
            7'h10:   r = {1'b1, 4'd9};
            7'h7F:   r = {blank_zero, 4'd0};
            default: r = {1'b0, 4'd0};
        endcase
        return r;
    endfunction

    always_comb begin
        cur    = {HEX1[6:0], HEX0[6:0]};
        same   = (cur == samp);
        fresh  = !last_ok || (cur != last_pat);
        d0     = dec(HEX0[6:0], 1'b0);
        d1     = dec(HEX1[6:0], 1'b1);
        legal  = d0[4] & d1[4];
        newval = 7'(d1[3:0]) * 7'd10 + 7'(d0[3:0]);
        expval = (VAL == VMAX) ? '0 : VAL + 7'd1;
    end

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            state     <= SETTLE;
            samp      <= '1;
            cnt       <= '0;
            last_pat  <= '1;
            last_ok   <= 1'b0;
            have_prev <= 1'b0;
            BCD0      <= '0;
            BCD1      <= '0;
            VAL       <= '0;
            VALID     <= 1'b0;
            ERR       <= 1'b0;
            SEQ_ERR   <= 1'b0;
        end else begin
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            SEQ_ERR <= 1'b0;
            if (!same) begin
                samp  <= cur;
                cnt   <= '0;
                state <= SETTLE;
            end else if (state == SETTLE) begin
                cnt <= cnt + 8'd1;
                // The edge that reaches STABLE_CYCLES is the single acceptance point
                // of this stable period; afterwards HOLD blocks further counting.
                if (cnt == SC - 8'd1) begin
                    state <= HOLD;
                    if (fresh) begin
                        last_pat <= cur;
                        last_ok  <= 1'b1;
                        if (legal) begin
                            BCD0      <= d0[3:0];
                            BCD1      <= d1[3:0];
                            VAL       <= newval;
                            VALID     <= 1'b1;
                            SEQ_ERR   <= have_prev && (newval != expval);
                            have_prev <= 1'b1;
                        end else begin
                            ERR       <= 1'b1;
                            have_prev <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader
//   Directed bench for seg7_reader. Two instances share the display bus: one
//   wraps at 99, the other at 59. Pulses are counted on the falling edge and
//   compared against hand-computed deltas per scenario.
module tb_seg7_reader;

    logic       CK = 1'b0;
    logic       RS = 1'b0;
    logic [7:0] HEX0 = 8'hFF;
    logic [7:0] HEX1 = 8'hFF;

    logic [3:0] bcd0_a, bcd1_a, bcd0_b, bcd1_b;
    logic [6:0] val_a, val_b;
    logic       valid_a, err_a, seq_a, valid_b, err_b, seq_b;

    int n_chk  = 0;
    int n_pass = 0;

    int va = 0, ea = 0, sa = 0, vb = 0, eb = 0, sb = 0;

    logic [7:0] gl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 CK = ~CK;

    seg7_reader #(.STABLE_CYCLES(4), .MAX_VAL(99)) u99 (
        .CK(CK), .RS(RS), .HEX0(HEX0), .HEX1(HEX1),
        .BCD0(bcd0_a), .BCD1(bcd1_a), .VAL(val_a),
        .VALID(valid_a), .ERR(err_a), .SEQ_ERR(seq_a)
    );

    seg7_reader #(.STABLE_CYCLES(4), .MAX_VAL(59)) u59 (
        .CK(CK), .RS(RS), .HEX0(HEX0), .HEX1(HEX1),
        .BCD0(bcd0_b), .BCD1(bcd1_b), .VAL(val_b),
        .VALID(valid_b), .ERR(err_b), .SEQ_ERR(seq_b)
    );

    always @(negedge CK) begin
        if (valid_a) va++;
        if (err_a)   ea++;
        if (seq_a)   sa++;
        if (valid_b) vb++;
        if (err_b)   eb++;
        if (seq_b)   sb++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic show2(input logic [7:0] h1, input logic [7:0] h0, input int n);
        HEX1 = h1;
        HEX0 = h0;
        repeat (n) @(negedge CK);
        #1;
    endtask

    task automatic show(input int v, input int n);
        show2((v >= 10) ? gl[v / 10] : 8'hFF, gl[v % 10], n);
    endtask

    // Counts falling edges after the current point until VALID is seen.
    task automatic first_valid(input int lim, output int k);
        k = 0;
        for (int i = 1; i <= lim; i++) begin
            @(negedge CK);
            #1;
            if (valid_a && k == 0) k = i;
        end
    endtask

    int k;
    int v0, e0, s0, s0b;

    initial begin
        // Reset state
        HEX1 = 8'hFF;
        HEX0 = 8'hC0;
        #12;
        check("rst_val", val_a, 0);
        check("rst_bcd", {bcd1_a, bcd0_a}, 0);
        check("rst_pulses", {valid_a, err_a, seq_a}, 0);

        // First acceptance latency: pattern sampled at e0, accepted at e4
        @(negedge CK);
        RS = 1'b1;
        first_valid(6, k);
        check("lat_edge", k, 5);
        check("lat_valid_cnt", va, 1);
        check("lat_val", val_a, 0);
        check("lat_seq", sa, 0);
        check("lat_err", ea, 0);

        // Count 0..12 from a fresh reset
        RS = 1'b0;
        @(negedge CK);
        #1;
        RS = 1'b1;
        v0 = va; s0 = sa; e0 = ea;
        for (int i = 0; i <= 12; i++) begin
            show(i, 8);
            check($sformatf("step_val_%0d", i), val_a, i);
        end
        check("step_valid_cnt", va - v0, 13);
        check("step_seq_cnt", sa - s0, 0);
        check("step_err_cnt", ea - e0, 0);
        check("step_bcd", {bcd1_a, bcd0_a}, 8'h12);

        // Short glitch 5 -> 4 -> 5 is ignored
        show(5, 8);
        v0 = va; s0 = sa; e0 = ea;
        show(4, 2);
        show(5, 8);
        check("glitch_valid", va - v0, 0);
        check("glitch_err", ea - e0, 0);
        check("glitch_seq", sa - s0, 0);
        check("glitch_val", val_a, 5);

        // Illegal glyph held: one ERR, then no SEQ_ERR on recovery
        show(3, 8);
        v0 = va; s0 = sa; e0 = ea;
        show2(8'hFF, 8'h8A, 10);
        check("ill_err", ea - e0, 1);
        check("ill_valid", va - v0, 0);
        check("ill_val", val_a, 3);
        show(4, 8);
        check("rec_valid", va - v0, 1);
        check("rec_seq", sa - s0, 0);
        check("rec_val", val_a, 4);
        show(7, 8);
        check("jump_seq", sa - s0, 1);
        check("jump_val", val_a, 7);

        // Wrap 98 -> 99 -> 00
        show(98, 8);
        v0 = va; s0 = sa; s0b = sb;
        show(99, 8);
        check("w99_seq_b", sb - s0b, 0);
        show2(8'hC0, 8'hC0, 8);
        check("wrap_valid", va - v0, 2);
        check("wrap_seq", sa - s0, 0);
        check("wrap_val", val_a, 0);
        check("wrap_seq_b", sb - s0b, 1);
        check("wrap_val_b", val_b, 0);

        // Wrap 58 -> 59 -> 00
        show(58, 8);
        s0 = sa; s0b = sb;
        show(59, 8);
        show2(8'hC0, 8'hC0, 8);
        check("w59_seq_b", sb - s0b, 0);
        check("w59_seq_a", sa - s0, 1);

        // Reset mid-count
        show(1, 8);
        check("pre_rst_val", val_a, 1);
        show(2, 2);
        #2;
        RS = 1'b0;
        #1;
        check("async_val", val_a, 0);
        check("async_bcd", {bcd1_a, bcd0_a}, 0);
        check("async_pulses", {valid_a, err_a, seq_a}, 0);
        @(negedge CK);
        RS = 1'b1;
        v0 = va; s0 = sa;
        first_valid(6, k);
        check("post_rst_edge", k, 5);
        check("post_rst_valid", va - v0, 1);
        check("post_rst_seq", sa - s0, 0);
        check("post_rst_val", val_a, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
